// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch/decode/execute/memory/writeback
// over one shared, variable-latency memory port and flags a sticky bus error on memory timeout.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic        ext_op,
  output logic [3:0]  alu_ctrl,
  output logic [3:0]  state,
  output logic        bus_err
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX_R = 4'd2,
    S_EX_I = 4'd3,
    S_MA   = 4'd4,
    S_MRD  = 4'd5,
    S_MWR  = 4'd6,
    S_WB   = 4'd7,
    S_WBM  = 4'd8,
    S_BR   = 4'd9,
    S_JAL  = 4'd10,
    S_JR   = 4'd11,
    S_ERR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_LUI = 4'b0011;

  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           st;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             is_rtype;
  logic             mem_busy;
  logic [3:0]       alu_fn;
  logic             unused_instr_bits;

  assign op                = instr[31:26];
  assign funct             = instr[5:0];
  assign is_rtype          = (op == OP_RTYPE);
  assign unused_instr_bits = ^instr[25:6];
  assign mem_busy          = (st == S_IF) || (st == S_MRD) || (st == S_MWR);
  assign state             = st;

  // ALU function for the current instruction; held through WB so the result register stays stable.
  always_comb begin
    alu_fn = ALU_ADD;
    if (is_rtype && funct == FN_SUB) alu_fn = ALU_SUB;
    else if (op == OP_ORI)           alu_fn = ALU_OR;
    else if (op == OP_LUI)           alu_fn = ALU_LUI;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_IF;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      if (mem_busy && !mem_ready) begin
        // A pending access waits; the cycle it would reach TIMEOUT aborts into ERR instead.
        if (wait_cnt == CNT_LAST) begin
          st      <= S_ERR;
          bus_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        case (st)
          S_IF: st <= S_ID;
          S_ID: begin
            case (op)
              OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB) st <= S_EX_R;
                else if (funct == FN_JR)                st <= S_JR;
                else                                    st <= S_IF;
              end
              OP_ORI, OP_LUI: st <= S_EX_I;
              OP_LW, OP_SW:   st <= S_MA;
              OP_BEQ:         st <= S_BR;
              OP_JAL:         st <= S_JAL;
              default:        st <= S_IF;
            endcase
          end
          S_EX_R, S_EX_I: st <= S_WB;
          S_MA:           st <= (op == OP_SW) ? S_MWR : S_MRD;
          S_MRD:          st <= S_WBM;
          S_ERR:          st <= S_ERR;
          default:        st <= S_IF;
        endcase
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred for unlisted states.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    reg_we   = 1'b0;
    reg_dst  = 2'd0;
    wd_sel   = 2'd0;
    alu_src  = 1'b0;
    ext_op   = 1'b0;
    alu_ctrl = 4'd0;
    if (!reset) begin
      case (st)
        S_IF: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_EX_R: alu_ctrl = alu_fn;
        S_EX_I: begin
          alu_src  = 1'b1;
          ext_op   = 1'b1;
          alu_ctrl = alu_fn;
        end
        S_WB: begin
          reg_we   = 1'b1;
          reg_dst  = is_rtype ? 2'd1 : 2'd0;
          alu_src  = !is_rtype;
          ext_op   = !is_rtype;
          alu_ctrl = alu_fn;
        end
        S_MA: begin
          alu_src  = 1'b1;
          alu_ctrl = ALU_ADD;
        end
        S_MRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MWR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
        end
        S_WBM: begin
          reg_we = 1'b1;
          wd_sel = 2'd1;
        end
        S_BR: begin
          alu_ctrl = ALU_SUB;
          pc_we    = zero;
          pc_sel   = 2'd1;
        end
        S_JAL: begin
          reg_we  = 1'b1;
          reg_dst = 2'd2;
          wd_sel  = 2'd2;
          pc_we   = 1'b1;
          pc_sel  = 2'd2;
        end
        S_JR: begin
          pc_we  = 1'b1;
          pc_sel = 2'd3;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed scenarios plus a random instruction stream with random
// memory latencies, checked every cycle against per-instruction control sequences built in the bench.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src, ext_op, bus_err;
  logic [1:0]  pc_sel, reg_dst, wd_sel;
  logic [3:0]  alu_ctrl, state;

  mc_ctrl_fsm #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .ext_op(ext_op), .alu_ctrl(alu_ctrl), .state(state), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] reg_dst, wd_sel;
    logic       alu_src, ext_op;
    logic [3:0] alu_ctrl;
    logic [3:0] state;
  } ctl_t;

  typedef enum int {K_NOP, K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_BAD} kind_t;

  int   total = 0;
  int   bad   = 0;
  logic exp_berr = 1'b0;
  logic [31:0] ir_model = 32'h0;

  function automatic ctl_t mk(input logic [3:0] s);
    ctl_t c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input ctl_t exp, input ctl_t mask, input bit chk_b, input string tag);
    ctl_t obs;
    obs.mem_req = mem_req;  obs.mem_we = mem_we;   obs.iord = iord;
    obs.ir_we = ir_we;      obs.pc_we = pc_we;     obs.pc_sel = pc_sel;
    obs.reg_we = reg_we;    obs.reg_dst = reg_dst; obs.wd_sel = wd_sel;
    obs.alu_src = alu_src;  obs.ext_op = ext_op;   obs.alu_ctrl = alu_ctrl;
    obs.state = state;
    total++;
    assert ((obs & mask) === (exp & mask)) else begin
      bad++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, obs & mask, exp & mask);
    end
    if (chk_b) begin
      total++;
      assert (bus_err === exp_berr) else begin
        bad++;
        $error("FAIL %s bus_err observed=%b expected=%b", tag, bus_err, exp_berr);
      end
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check just after, let the rising edge act.
  task automatic step(input ctl_t exp, input logic rdy, input logic z, input string tag);
    @(negedge clk);
    reset = 1'b0; mem_ready = rdy; zero = z; instr = ir_model;
    #1;
    chk(exp, '1, 1'b1, tag);
  endtask

  task automatic rst_cycle(input logic [3:0] st_exp, input bit chk_st, input bit chk_b, input string tag);
    ctl_t m = '1;
    if (!chk_st) m.state = 4'h0;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; instr = ir_model;
    #1;
    chk(mk(st_exp), m, chk_b, tag);
  endtask

  function automatic ctl_t fetch_cw(input logic done);
    ctl_t c = mk(4'd0);
    c.mem_req = 1'b1;
    c.ir_we = done;
    c.pc_we = done;
    return c;
  endfunction

  function automatic ctl_t data_cw(input logic wr);
    ctl_t c = mk(wr ? 4'd6 : 4'd5);
    c.mem_req = 1'b1;
    c.iord = 1'b1;
    c.mem_we = wr;
    return c;
  endfunction

  // Access outstanding for d wait cycles, completing on cycle d+1; request signals must not move.
  task automatic mem_phase(input ctl_t wait_c, input ctl_t done_c, input int d, input string tag);
    for (int i = 0; i < d; i++) step(wait_c, 1'b0, rnd(), tag);
    step(done_c, 1'b1, rnd(), tag);
  endtask

  function automatic logic [31:0] gen(input kind_t k);
    logic [4:0]  rs = 5'($urandom), rt = 5'($urandom), rd = 5'($urandom);
    logic [15:0] imm = 16'($urandom);
    logic [25:0] tgt = 26'($urandom);
    case (k)
      K_ADD:   return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      K_SUB:   return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      K_ORI:   return {6'h0D, rs, rt, imm};
      K_LUI:   return {6'h0F, 5'd0, rt, imm};
      K_LW:    return {6'h23, rs, rt, imm};
      K_SW:    return {6'h2B, rs, rt, imm};
      K_BEQ:   return {6'h04, rs, rt, imm};
      K_JAL:   return {6'h03, tgt};
      K_JR:    return {6'h00, rs, 15'd0, 6'h08};
      K_BAD:   return rnd() ? {6'h3F, tgt} : {6'h00, rs, rt, rd, 5'd0, 6'h25};
      default: return 32'h0;
    endcase
  endfunction

  // Expected control words for one instruction, from fetch to its last cycle.
  task automatic run_instr(input kind_t k, input logic [31:0] ins, input int df, input int dm,
                           input logic bz, input string tag);
    ctl_t e;
    logic [3:0] a;
    mem_phase(fetch_cw(1'b0), fetch_cw(1'b1), df, {tag, "/if"});
    ir_model = ins;
    step(mk(4'd1), rnd(), rnd(), {tag, "/id"});
    case (k)
      K_ADD, K_SUB: begin
        a = (k == K_ADD) ? 4'b0010 : 4'b0110;
        e = mk(4'd2); e.alu_ctrl = a;
        step(e, rnd(), rnd(), {tag, "/ex_r"});
        e = mk(4'd7); e.reg_we = 1'b1; e.reg_dst = 2'd1; e.alu_ctrl = a;
        step(e, rnd(), rnd(), {tag, "/wb"});
      end
      K_ORI, K_LUI: begin
        a = (k == K_ORI) ? 4'b0001 : 4'b0011;
        e = mk(4'd3); e.alu_src = 1'b1; e.ext_op = 1'b1; e.alu_ctrl = a;
        step(e, rnd(), rnd(), {tag, "/ex_i"});
        e = mk(4'd7); e.reg_we = 1'b1; e.alu_src = 1'b1; e.ext_op = 1'b1; e.alu_ctrl = a;
        step(e, rnd(), rnd(), {tag, "/wb"});
      end
      K_LW, K_SW: begin
        e = mk(4'd4); e.alu_src = 1'b1; e.alu_ctrl = 4'b0010;
        step(e, rnd(), rnd(), {tag, "/ma"});
        mem_phase(data_cw(k == K_SW), data_cw(k == K_SW), dm, {tag, "/mem"});
        if (k == K_LW) begin
          e = mk(4'd8); e.reg_we = 1'b1; e.wd_sel = 2'd1;
          step(e, rnd(), rnd(), {tag, "/wbm"});
        end
      end
      K_BEQ: begin
        e = mk(4'd9); e.alu_ctrl = 4'b0110; e.pc_we = bz; e.pc_sel = 2'd1;
        step(e, rnd(), bz, {tag, "/br"});
      end
      K_JAL: begin
        e = mk(4'd10); e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
        e.pc_we = 1'b1; e.pc_sel = 2'd2;
        step(e, rnd(), rnd(), {tag, "/jal"});
      end
      K_JR: begin
        e = mk(4'd11); e.pc_we = 1'b1; e.pc_sel = 2'd3;
        step(e, rnd(), rnd(), {tag, "/jr"});
      end
      default: ;
    endcase
  endtask

  initial begin
    ctl_t e;
    kind_t k;
    int df, dm;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; instr = 32'h0;

    // Reset held 3 cycles with mem_ready high: no strobes, then fetch starts at once.
    rst_cycle(4'd0, 1'b0, 1'b0, "reset0");
    rst_cycle(4'd0, 1'b1, 1'b1, "reset1");
    rst_cycle(4'd0, 1'b1, 1'b1, "reset2");

    run_instr(K_ADD, 32'h00221820, 0, 0, 1'b0, "add");
    run_instr(K_LW,  32'h8C040008, 0, 3, 1'b0, "lw_wait3");
    run_instr(K_BEQ, gen(K_BEQ), 0, 0, 1'b1, "beq_taken");
    run_instr(K_BEQ, gen(K_BEQ), 0, 0, 1'b0, "beq_not");
    run_instr(K_JAL, 32'h0C000010, 0, 0, 1'b0, "jal");
    run_instr(K_JR,  32'h03E00008, 0, 0, 1'b0, "jr");
    run_instr(K_NOP, 32'h00000000, 2, 0, 1'b0, "nop");
    run_instr(K_SW,  gen(K_SW), 1, 0, 1'b0, "sw_b2b");
    run_instr(K_BAD, gen(K_BAD), 0, 0, 1'b0, "unknown");
    // Last-chance acceptance: mem_ready on the 16th waiting cycle is still taken.
    run_instr(K_LW,  gen(K_LW), 15, 15, 1'b0, "lw_edge");

    for (int n = 0; n < 80; n++) begin
      k  = kind_t'($urandom_range(0, 10));
      df = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
      dm = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
      run_instr(k, gen(k), df, dm, rnd(), "rand");
    end

    // Reset mid-access: pending load dropped, no strobe in the reset cycle.
    ir_model = gen(K_LW);
    mem_phase(fetch_cw(1'b0), fetch_cw(1'b1), 0, "abort/if");
    step(mk(4'd1), rnd(), rnd(), "abort/id");
    e = mk(4'd4); e.alu_src = 1'b1; e.alu_ctrl = 4'b0010;
    step(e, rnd(), rnd(), "abort/ma");
    step(data_cw(1'b0), 1'b0, rnd(), "abort/mrd");
    step(data_cw(1'b0), 1'b0, rnd(), "abort/mrd");
    rst_cycle(4'd5, 1'b1, 1'b1, "abort/reset");
    run_instr(K_ORI, gen(K_ORI), 0, 0, 1'b0, "after_abort");

    // Store that never completes times out into ERR.
    run_instr(K_NOP, 32'h0, 0, 0, 1'b0, "pre_to");
    ir_model = gen(K_SW);
    mem_phase(fetch_cw(1'b0), fetch_cw(1'b1), 0, "sw_to/if");
    step(mk(4'd1), rnd(), rnd(), "sw_to/id");
    e = mk(4'd4); e.alu_src = 1'b1; e.alu_ctrl = 4'b0010;
    step(e, rnd(), rnd(), "sw_to/ma");
    for (int i = 0; i < 16; i++) step(data_cw(1'b1), 1'b0, rnd(), "sw_to/wait");
    exp_berr = 1'b1;
    for (int i = 0; i < 4; i++) step(mk(4'd15), rnd(), rnd(), "sw_to/err");
    rst_cycle(4'd15, 1'b1, 1'b1, "sw_to/reset");
    exp_berr = 1'b0;

    // Fetch that never completes: 16 waiting cycles, then ERR is sticky until reset.
    for (int i = 0; i < 16; i++) step(fetch_cw(1'b0), 1'b0, rnd(), "if_to/wait");
    exp_berr = 1'b1;
    for (int i = 0; i < 6; i++) step(mk(4'd15), rnd(), rnd(), "if_to/err");
    rst_cycle(4'd15, 1'b1, 1'b1, "if_to/reset");
    exp_berr = 1'b0;
    run_instr(K_JAL, gen(K_JAL), 0, 0, 1'b0, "after_err");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
